// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and constants for the two-way instruction cache
package icache_pkg;

    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_TAG_W      = 20;

    localparam logic [2:0] RD_WORD = 3'b010;
    localparam logic [2:0] RD_LINE = 3'b100;

    typedef logic [31:0] u32_t;
    typedef u32_t [ICACHE_LINE_WORDS-1:0] line_t;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_LOOKUP  = 3'd1,
        OP_IDX_INV = 3'd2,
        OP_HIT_INV = 3'd3
    } icache_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REFILL,
        S_RESP
    } icache_state_t;

endpackage

// File: rtl/icache_way_ram.sv
// rtl/icache_way_ram.sv - one cache way: tag and line storage, sync read with write-first bypass
module icache_way_ram
    import icache_pkg::*;
#(
    parameter int SET_IDX_W = 8
) (
    input  logic                    clk,
    input  logic                    re,
    input  logic [SET_IDX_W-1:0]    raddr,
    input  logic                    we,
    input  logic [SET_IDX_W-1:0]    waddr,
    input  logic [ICACHE_TAG_W-1:0] wtag,
    input  line_t                   wline,
    output logic [ICACHE_TAG_W-1:0] rtag,
    output line_t                   rline
);

    localparam int NSETS = 1 << SET_IDX_W;

    logic [ICACHE_TAG_W-1:0] tag_mem  [NSETS];
    line_t                   data_mem [NSETS];

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[waddr]  <= wtag;
            data_mem[waddr] <= wline;
        end
        if (re) begin
            // a read of the set being written returns the new contents
            if (we && (waddr == raddr)) begin
                rtag  <= wtag;
                rline <= wline;
            end else begin
                rtag  <= tag_mem[raddr];
                rline <= data_mem[raddr];
            end
        end
    end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - two-way set-associative instruction cache; ICACHE_LRU_EN selects per-set LRU replacement
module icache
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int SET_IDX_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] idx,
    input  logic [2:0]  op,
    input  logic [31:0] pa,
    input  logic        is_cached,
    input  logic        stall,
    output logic        ready,
    output logic [31:0] data,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);

    localparam int NSETS = 1 << SET_IDX_W;

    icache_state_t           state, state_nxt;
    icache_op_t              op_r;
    logic [SET_IDX_W-1:0]    set_r;
    logic [1:0]              off_r;
    logic [31:0]             pa_r;
    logic                    cached_r;
    logic [1:0]              beat_cnt;
    line_t                   line_buf, refill_line;
    logic [31:0]             crit_word;
    logic [NSETS-1:0]        valid [2];
    logic [ICACHE_TAG_W-1:0] rtag  [2];
    line_t                   rline [2];
    logic [1:0]              way_hit;
    logic                    hit, hit_way, victim, policy_way;
    logic                    req_ok, lookup_done, accept, fill_we, beat_in;
    logic                    unused_idx;

    assign unused_idx = ^idx[1:0];

    assign way_hit[0] = valid[0][set_r] && (rtag[0] == pa_r[31:12]);
    assign way_hit[1] = valid[1][set_r] && (rtag[1] == pa_r[31:12]);
    assign hit        = |way_hit;
    assign hit_way    = way_hit[1];

    // ops 4..7 fall outside the enum and are never accepted
    assign req_ok      = (op != 3'd0) && !op[2] && !stall;
    assign lookup_done = !((op_r == OP_LOOKUP) && (!cached_r || !hit));
    assign accept      = req_ok && ((state == S_IDLE) || (state == S_RESP) ||
                                    ((state == S_LOOKUP) && lookup_done));

    assign beat_in = (state == S_REFILL) && ret_valid;
    assign fill_we = beat_in && ret_last && cached_r;

    always_comb begin
        refill_line           = line_buf;
        refill_line[beat_cnt] = ret_data;
    end

`ifdef ICACHE_LRU_EN
    logic [NSETS-1:0] lru;

    // lru[set] names the least recently used way of that set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru <= '0;
        end else if (fill_we) begin
            lru[set_r] <= ~victim;
        end else if ((state == S_LOOKUP) && (op_r == OP_LOOKUP) && cached_r && hit) begin
            lru[set_r] <= ~hit_way;
        end
    end

    assign policy_way = lru[set_r];
`else
    logic toggle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) toggle <= 1'b0;
        else        toggle <= ~toggle;
    end

    assign policy_way = toggle;
`endif

    assign victim = !valid[0][set_r] ? 1'b0 :
                    !valid[1][set_r] ? 1'b1 : policy_way;

    for (genvar w = 0; w < 2; w++) begin : g_way
        icache_way_ram #(.SET_IDX_W(SET_IDX_W)) u_ram (
            .clk   (clk),
            .re    (accept),
            .raddr (idx[4 +: SET_IDX_W]),
            .we    (fill_we && (victim == 1'(w))),
            .waddr (set_r),
            .wtag  (pa_r[31:12]),
            .wline (refill_line),
            .rtag  (rtag[w]),
            .rline (rline[w])
        );
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        data      = '0;
        rd_req    = 1'b0;
        rd_type   = '0;
        rd_addr   = '0;
        case (state)
            S_IDLE: if (accept) state_nxt = S_LOOKUP;
            S_LOOKUP: begin
                if (!lookup_done) begin
                    state_nxt = S_MISS;
                end else begin
                    ready = 1'b1;
                    if (op_r == OP_LOOKUP) data = rline[hit_way][off_r];
                    if (!stall) state_nxt = accept ? S_LOOKUP : S_IDLE;
                end
            end
            S_MISS: begin
                rd_req  = 1'b1;
                rd_type = cached_r ? RD_LINE : RD_WORD;
                rd_addr = cached_r ? {pa_r[31:4], 4'b0} : pa_r;
                if (rd_rdy) state_nxt = S_REFILL;
            end
            S_REFILL: if (ret_valid && ret_last) state_nxt = S_RESP;
            S_RESP: begin
                ready = 1'b1;
                data  = crit_word;
                if (!stall) state_nxt = accept ? S_LOOKUP : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_r      <= OP_NOP;
            set_r     <= '0;
            off_r     <= '0;
            pa_r      <= '0;
            cached_r  <= 1'b0;
            beat_cnt  <= '0;
            line_buf  <= '0;
            crit_word <= '0;
            valid[0]  <= '0;
            valid[1]  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_r     <= icache_op_t'(op);
                set_r    <= idx[4 +: SET_IDX_W];
                off_r    <= idx[3:2];
                pa_r     <= pa;
                cached_r <= is_cached;
            end
            if (beat_in) begin
                line_buf <= refill_line;
                // uncached fetches return their single word as beat 0
                if (beat_cnt == (cached_r ? off_r : 2'd0)) crit_word <= ret_data;
                beat_cnt <= ret_last ? 2'd0 : beat_cnt + 2'd1;
                if (fill_we) valid[victim][set_r] <= 1'b1;
            end
            if (state == S_LOOKUP) begin
                if (op_r == OP_IDX_INV)        valid[pa_r[0]][set_r]  <= 1'b0;
                if ((op_r == OP_HIT_INV) && hit) valid[hit_way][set_r] <= 1'b0;
            end
        end
    end

    a_beat_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !((state == S_REFILL) && ret_valid && !ret_last && (beat_cnt == 2'(LINE_WORDS-1))));

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - table-driven self-checking bench for icache
module tb_icache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] idx = '0;
    logic [2:0]  op = '0;
    logic [31:0] pa = '0;
    logic        is_cached = 1'b0;
    logic        stall = 1'b0;
    logic        ready;
    logic [31:0] data;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy = 1'b0;
    logic        ret_valid = 1'b0;
    logic        ret_last = 1'b0;
    logic [31:0] ret_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] pa;
        logic        cached;
        logic        exp_miss;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    vec_t vecs[15];

    icache dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx),
        .op        (op),
        .pa        (pa),
        .is_cached (is_cached),
        .stall     (stall),
        .ready     (ready),
        .data      (data),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic c,
                                input logic m, input logic [31:0] d, input string n);
        vec_t v;
        v.op = o; v.pa = a; v.cached = c; v.exp_miss = m; v.exp_data = d; v.name = n;
        return v;
    endfunction

    // page 0x1C000 holds 0x11,0x22,0x33,0x44 in every line; elsewhere address ^ 0x5A5A0000
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:12] == 20'h1C000) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] base;
        int          nb;
        @(negedge clk);
        op = v.op; pa = v.pa; idx = v.pa[11:0]; is_cached = v.cached;
        @(negedge clk);
        op = 3'd0;
        if (!v.exp_miss) begin
            chk({v.name, " ready"}, {31'd0, ready}, 32'd1);
            if (v.op != 3'd3) chk({v.name, " data"}, data, v.exp_data);
            chk({v.name, " no rd_req"}, {31'd0, rd_req}, 32'd0);
        end else begin
            chk({v.name, " miss not ready"}, {31'd0, ready}, 32'd0);
            @(negedge clk);
            chk({v.name, " rd_req"}, {31'd0, rd_req}, 32'd1);
            chk({v.name, " rd_type"}, {29'd0, rd_type}, v.cached ? 32'd4 : 32'd2);
            chk({v.name, " rd_addr"}, rd_addr, v.cached ? {v.pa[31:4], 4'b0} : v.pa);
            @(negedge clk);
            chk({v.name, " rd_req held"}, {31'd0, rd_req}, 32'd1);
            rd_rdy = 1'b1;
            @(negedge clk);
            rd_rdy = 1'b0;
            base = v.cached ? {v.pa[31:4], 4'b0} : v.pa;
            nb   = v.cached ? 4 : 1;
            for (int k = 0; k < nb; k++) begin
                ret_valid = 1'b1;
                ret_data  = mem_word(base + 32'(4 * k));
                ret_last  = (k == nb - 1);
                @(negedge clk);
            end
            ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
            chk({v.name, " resp ready"}, {31'd0, ready}, 32'd1);
            chk({v.name, " resp data"}, data, v.exp_data);
        end
    endtask

    initial begin
        logic [31:0] exp_b2b [4];
        exp_b2b = '{32'h11, 32'h22, 32'h33, 32'h44};

        vecs[0]  = mk(3'd1, 32'h1C00_0000, 1'b1, 1'b1, 32'h0000_0011, "cold");
        vecs[1]  = mk(3'd1, 32'h1C00_0000, 1'b1, 1'b0, 32'h0000_0011, "rehit");
        vecs[2]  = mk(3'd1, 32'h1C00_0004, 1'b1, 1'b0, 32'h0000_0022, "hit w1");
        vecs[3]  = mk(3'd1, 32'h1C00_0018, 1'b1, 1'b1, 32'h0000_0033, "cold off8");
        vecs[4]  = mk(3'd1, 32'h1C00_001C, 1'b1, 1'b0, 32'h0000_0044, "hit off C");
        vecs[5]  = mk(3'd1, 32'h1FD0_0000, 1'b0, 1'b1, 32'h458A_0000, "uncached");
        vecs[6]  = mk(3'd1, 32'h1FD0_0000, 1'b0, 1'b1, 32'h458A_0000, "uncached again");
        vecs[7]  = mk(3'd1, 32'h0000_1000, 1'b1, 1'b1, 32'h5A5A_1000, "set0 second tag");
        vecs[8]  = mk(3'd1, 32'h1C00_000C, 1'b1, 1'b0, 32'h0000_0044, "way0 kept");
        vecs[9]  = mk(3'd1, 32'h0000_1008, 1'b1, 1'b0, 32'h5A5A_1008, "way1 hit");
        vecs[10] = mk(3'd3, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_0000, "hit_inv");
        vecs[11] = mk(3'd1, 32'h0000_1004, 1'b1, 1'b1, 32'h5A5A_1004, "after hit_inv");
        vecs[12] = mk(3'd2, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0000, "idx_inv way1");
        vecs[13] = mk(3'd1, 32'h1C00_0000, 1'b1, 1'b0, 32'h0000_0011, "idx_inv keeps way0");
        vecs[14] = mk(3'd1, 32'h0000_1000, 1'b1, 1'b1, 32'h5A5A_1000, "idx_inv cleared way1");

        repeat (2) @(negedge clk);
        chk("reset ready", {31'd0, ready}, 32'd0);
        chk("reset data", data, 32'd0);
        chk("reset rd_req", {31'd0, rd_req}, 32'd0);
        chk("reset rd_type", {29'd0, rd_type}, 32'd0);
        chk("reset rd_addr", rd_addr, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // back-to-back hits, one response per cycle
        @(negedge clk);
        op = 3'd1; pa = 32'h1C00_0000; idx = 12'h000; is_cached = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("b2b ready %0d", k), {31'd0, ready}, 32'd1);
            chk($sformatf("b2b data %0d", k), data, exp_b2b[k]);
            if (k < 3) begin
                pa  = 32'h1C00_0000 + 32'(4 * (k + 1));
                idx = pa[11:0];
            end else begin
                op = 3'd0;
            end
        end

        // stalled hit response holds
        @(negedge clk);
        op = 3'd1; pa = 32'h1C00_0008; idx = 12'h008;
        @(negedge clk);
        op = 3'd0; stall = 1'b1;
        chk("stall ready 0", {31'd0, ready}, 32'd1);
        chk("stall data 0", data, 32'h33);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall ready %0d", k), {31'd0, ready}, 32'd1);
            chk($sformatf("stall data %0d", k), data, 32'h33);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("stall released", {31'd0, ready}, 32'd0);

        // third tag in set 0
        run_vec(mk(3'd1, 32'h0000_1000, 1'b1, 1'b0, 32'h5A5A_1000, "touch tag1"));
        run_vec(mk(3'd1, 32'h0000_2000, 1'b1, 1'b1, 32'h5A5A_2000, "third tag"));
        run_vec(mk(3'd1, 32'h0000_2004, 1'b1, 1'b0, 32'h5A5A_2004, "third tag hit"));
`ifdef ICACHE_LRU_EN
        run_vec(mk(3'd1, 32'h1C00_0000, 1'b1, 1'b1, 32'h0000_0011, "lru evicted"));
        run_vec(mk(3'd1, 32'h0000_2008, 1'b1, 1'b0, 32'h5A5A_2008, "lru mru kept"));
`endif

        // reset in the middle of a refill
        @(negedge clk);
        op = 3'd1; pa = 32'h0000_3040; idx = 12'h040; is_cached = 1'b1;
        @(negedge clk);
        op = 3'd0;
        @(negedge clk);
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ret_valid = 1'b1; ret_last = 1'b0; ret_data = mem_word(32'h0000_3040 + 32'(4 * k));
            @(negedge clk);
        end
        ret_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst ready", {31'd0, ready}, 32'd0);
        chk("midrst data", data, 32'd0);
        chk("midrst rd_req", {31'd0, rd_req}, 32'd0);
        chk("midrst rd_type", {29'd0, rd_type}, 32'd0);
        chk("midrst rd_addr", rd_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(3'd1, 32'h0000_3040, 1'b1, 1'b1, 32'h5A5A_3040, "after midrst"));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Two-way set-associative, read-only instruction cache between Fetch1, which issues index/op/physical address, and Fetch2, which consumes `ready`/`data`. It looks up 8 KiB of 16-byte lines and refills misses over a simple line-burst read bus. It also serves uncached word fetches and CACOP index/hit invalidates.

## Interface
- `LINE_WORDS`, default 4: words per line. Fixed at 4; `idx[3:2]` is the word offset.
- `SET_IDX_W`, default 8: set index width, taken from `idx[11:4]`. `SET_IDX_W` plus 4 must equal 12.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `idx` in 12: virtual index (page offset) from Fetch1.
- `op` in 3: 0 NOP, 1 LOOKUP, 2 IDX_INV, 3 HIT_INV; 4–7 are treated as NOP.
- `pa` in 32: physical address. The tag is `pa[31:12]`. For IDX_INV, `pa[0]` selects the way.
- `is_cached` in 1: 0 forces an uncached single-word read.
- `stall` in 1: downstream stall from Fetch2.
- `ready` out 1: response valid.
- `data` out 32: instruction word.
- `rd_req` out 1: memory read request.
- `rd_type` out 3: 3'b010 means word, 3'b100 means line.
- `rd_addr` out 32: read address.
- `rd_rdy` in 1: memory accepted the request.
- `ret_valid` in 1: return beat valid.
- `ret_last` in 1: final beat.
- `ret_data` in 32: beat data.

## Operation
- States:
  - IDLE: no request in flight.
  - LOOKUP: compare cycle.
  - MISS: request on the bus.
  - REFILL: collecting beats.
  - RESP: critical word out.
- A request is accepted when `op`≠NOP and `stall`=0, in IDLE, or in LOOKUP/RESP while the current response is being consumed. `idx`, `op`, `pa`, `is_cached` are registered and the way RAMs are read at `idx[11:4]`.
- LOOKUP, cached: hit = valid && tag==`pa[31:12]` in either way.
  - Hit: `ready`=1, `data`=word `idx[3:2]` of the hit way.
  - Miss: go to MISS.
- LOOKUP, uncached: always go to MISS.
- MISS: `rd_req`=1 held until `rd_rdy`=1 in the same cycle.
  - Cached: `rd_type`=line, `rd_addr`={`pa[31:4]`,4'b0}.
  - Uncached: `rd_type`=word, `rd_addr`=`pa`.
- REFILL: beat counter 0..LINE_WORDS-1 fills a line buffer and captures the beat equal to `idx[3:2]` (uncached: beat 0).
  - On `ret_last`, a cached refill writes tag, data and valid into the victim way, then the FSM moves to RESP.
  - Uncached never allocates.
- Victim selection: an invalid way first (way 0 if both are invalid); otherwise the replacement policy (see Configuration).
- IDX_INV: clear valid[`idx[11:4]`][`pa[0]`]. `ready`=1 in LOOKUP, `data`=0.
- HIT_INV: clear valid of the hit way, if any. `ready`=1 in LOOKUP.
- Consumption: a response is consumed when `ready`=1 and `stall`=0. While `stall`=1, `ready` and `data` hold unchanged.
- Valid bits are flops cleared by reset. Tag and data RAMs are not reset.

## Timing
- Reset values: `ready`=0, `data`=0, `rd_req`=0, `rd_type`=0, `rd_addr`=0, state IDLE, counter 0.
- Hit latency: request at T gives `ready` at T+1. Back-to-back hits sustain 1 per cycle.
- Miss: detected at T+1; `rd_req` asserted from T+2; `ready`=1 the cycle after `ret_last`.
- No new request is accepted in MISS or REFILL. Fetch1 holds its request.
- A refill always completes; the bus has no abort. Reset mid-refill returns to IDLE, and the in-flight line is discarded and stays invalid.
- `ret_valid` without `ret_last` past beat LINE_WORDS-1 is a protocol error and is asserted on in simulation.
- A same-set back-to-back lookup immediately after a refill must see the newly written line. Bypass the way RAM on a same-cycle write/read conflict.

## Configuration
- `ICACHE_LRU_EN` defined: a 1-bit LRU per set, updated on hit and on refill. The victim is the least recently used way.
- Undefined: the victim comes from a free-running 1-bit toggle, advanced every cycle.

## Structure
- Package `icache_pkg`:
  - `icache_op_t` enum.
  - `rd_type` constants `RD_WORD`/`RD_LINE`.
  - `ICACHE_TAG_W`=20.
  - `icache_state_t`.
  - Line type (LINE_WORDS×u32_t).
- Sub-module `icache_way_ram`: one instance per way. It holds tag and line data with sync read and write-first bypass.

## Test plan
- Cold LOOKUP at `pa`=0x1C000000 (memory returns 0x11,0x22,0x33,0x44) → `rd_req` line at 0x1C000000, then `ready`=1 with `data`=0x11. A repeat lookup hits at T+1 with no `rd_req`.
- Lookup at offset 0x8 (cold) → `data`=0x33 after refill. Back-to-back lookups of 0x0,0x4,0x8,0xC → 4 consecutive `ready` cycles.
- Uncached lookup at 0x1FD00000 → word `rd_req` at that address, `data`=ret beat. A repeat lookup misses again.
- Three tags mapping to set 0 with `ICACHE_LRU_EN` → the third evicts the least recently used tag. The evicted tag misses on re-access.
- HIT_INV on a cached line → `ready`=1, and the next lookup misses. IDX_INV with `pa[0]`=1 clears only way 1.
- `stall`=1 for 3 cycles during a hit response → `ready`/`data` stable. Reset asserted during REFILL → all outputs 0 and the line stays invalid.
